// File: rtl/regfile_multiport.sv
// Purpose : parametrised integer register file, NUM_READ synchronous read ports, one write port,
//           optional hardwired zero entry and a hardware clear sweep after reset / on clear_req.
// Latency : read 1 cycle (rd_addr -> rd_data), write 1 cycle to the array; clear sweep DEPTH cycles.
// Backpressure: none on the port interface; while busy=1 writes are dropped and every read returns 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data single write port
//   rd_addr              NUM_READ packed read addresses, port k at [k*AW +: AW]
//   rd_data              NUM_READ packed registered read data, port k at [k*XLEN +: XLEN]
//   clear_req            single-cycle request for a full clear sweep (ignored while busy)
//   busy                 high while the clear sweep runs
//
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle accepted write to matching read ports.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [NUM_READ*AW-1:0]   rd_addr,
  output logic [NUM_READ*XLEN-1:0] rd_data,
  input  logic                     clear_req,
  output logic                     busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // ptr carries one extra bit so the comparisons against DEPTH work for non-power-of-two depths.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_t          state, state_nxt;
  logic [AW:0]     ptr, ptr_nxt;
  logic            wr_ok;
  logic [XLEN-1:0] mem [DEPTH];

  assign busy = (state == CLEAR);

  // A write lands only in IDLE, never alongside a clear request, and never on an
  // out-of-range or hardwired-zero address.
  assign wr_ok = (state == IDLE) && !clear_req && wr_en &&
                 ({1'b0, wr_addr} < DEPTH_W) &&
                 !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ONE;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Array has no reset of its own; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr[AW-1:0]] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            readable;
    logic [XLEN-1:0] rd_q;

    assign ra       = rd_addr[k*AW +: AW];
    assign readable = ({1'b0, ra} < DEPTH_W) && !(ZERO_REG && (ra == '0));

    // Zero forcing (sweep, range, zero entry) outranks forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else if ((state == CLEAR) || !readable) begin
        rd_q <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_ok && (wr_addr == ra)) begin
        rd_q <= wr_data;
`else
`endif
      end else begin
        rd_q <= mem[ra];
      end
    end

    assign rd_data[k*XLEN +: XLEN] = rd_q;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Purpose : checks regfile_multiport at DEPTH=32/2 ports and DEPTH=24/3 ports, sharing one stimulus stream.
// Latency : expected values are queued at each rising edge and compared 1 time unit later.
// Backpressure: none; the monitor consumes one expected entry per instance per clock.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [14:0] rd_addr = '0;
  logic        clear_req = 1'b0;
  logic [63:0] rd_data_a;
  logic [95:0] rd_data_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int failures = 0;
  bit run = 1'b1;

  always #5 clk = ~clk;

  regfile_multiport #(.XLEN(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr[9:0]), .rd_data(rd_data_a), .clear_req(clear_req), .busy(busy_a)
  );

  regfile_multiport #(.XLEN(32), .DEPTH(24), .NUM_READ(3), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .clear_req(clear_req), .busy(busy_b)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic             busy;
    logic [2:0][31:0] rd;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] mem_m [2][32];
  int          left_m [2];          // clear cycles still to run
  int          dep [2] = '{32, 24};
  int          nrd [2] = '{2, 3};

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      int   wa;
      bit   wv;
      e  = '0;
      wa = int'(wr_addr);
      if (!rst_n) begin
        left_m[i] = dep[i];
        for (int a = 0; a < 32; a++) mem_m[i][a] = '0;
      end else if (left_m[i] > 0) begin
        left_m[i]--;
      end else begin
        wv = wr_en && !clear_req && (wa < dep[i]) && (wa != 0);
        for (int k = 0; k < nrd[i]; k++) begin
          int a;
          a = int'(rd_addr[k*5 +: 5]);
          if (a < dep[i] && a != 0) begin
            e.rd[k] = mem_m[i][a];
`ifdef REGFILE_BYPASS_EN
            if (wv && wa == a) e.rd[k] = wr_data;
`endif
          end
        end
        if (clear_req) begin
          left_m[i] = dep[i];
          for (int a = 0; a < 32; a++) mem_m[i][a] = '0;
        end else if (wv) begin
          mem_m[i][wa] = wr_data;
        end
      end
      e.busy = (left_m[i] > 0);
      if (i == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (run) model_step();
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_one(input int i, input exp_t e);
    logic [31:0] act;
    for (int k = 0; k < nrd[i]; k++) begin
      act = (i == 0) ? rd_data_a[k*32 +: 32] : rd_data_b[k*32 +: 32];
      chk($sformatf("%s_rd%0d", (i == 0) ? "A" : "B", k), act, e.rd[k]);
    end
    chk($sformatf("%s_busy", (i == 0) ? "A" : "B"),
        {31'b0, (i == 0) ? busy_a : busy_b}, {31'b0, e.busy});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) mon_one(0, qa.pop_front());
      if (qb.size() > 0) mon_one(1, qb.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [14:0] ra3(input int a, input int b, input int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic drive(input logic we, input int wa, input logic [31:0] wd,
                       input logic cr, input logic [14:0] ra);
    @(negedge clk);
    wr_en     = we;
    wr_addr   = 5'(wa);
    wr_data   = wd;
    clear_req = cr;
    rd_addr   = ra;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 32'h0, 1'b0, 15'($urandom));
  endtask

  task automatic async_rst_checks();
    #1;
    chk("A_busy_async", {31'b0, busy_a}, 32'd1);
    chk("B_busy_async", {31'b0, busy_b}, 32'd1);
    chk("A_rd0_async", rd_data_a[31:0], 32'h0);
    chk("B_rd2_async", rd_data_b[95:64], 32'h0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    async_rst_checks();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    async_rst_checks();
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep after reset, then read every address on each port.
    for (int i = 0; i < 72; i++) drive(1'b0, 0, 32'h0, 1'b0, ra3(i % 32, (i + 1) % 32, (i + 2) % 32));

    // Write then read on both ports.
    drive(1'b1, 5, 32'hDEADBEEF, 1'b0, ra3(0, 0, 0));
    drive(1'b0, 0, 32'h0, 1'b0, ra3(5, 5, 5));
    idle(1);

    // Hardwired zero entry.
    drive(1'b1, 0, 32'h12345678, 1'b0, ra3(1, 2, 3));
    drive(1'b0, 0, 32'h0, 1'b0, ra3(0, 0, 0));

    // Same-cycle read/write of address 7.
    drive(1'b1, 7, 32'h1, 1'b0, ra3(0, 0, 0));
    drive(1'b1, 7, 32'h2, 1'b0, ra3(7, 7, 7));
    drive(1'b0, 0, 32'h0, 1'b0, ra3(7, 7, 7));

    // Fill, clear with a colliding write, second clear request mid-sweep.
    for (int a = 1; a < 32; a++) drive(1'b1, a, $urandom | 32'h1, 1'b0, 15'($urandom));
    drive(1'b1, 3, 32'hAAAA5555, 1'b1, ra3(3, 3, 3));
    for (int i = 0; i < 40; i++) drive(1'b0, 0, 32'h0, (i == 5), ra3(i % 32, 3, 30));
    for (int i = 0; i < 32; i++) drive(1'b0, 0, 32'h0, 1'b0, ra3(i, 31 - i, i));

    // Out-of-range address for the 24-entry file.
    drive(1'b1, 30, 32'hCAFEF00D, 1'b0, ra3(0, 0, 0));
    drive(1'b0, 0, 32'h0, 1'b0, ra3(30, 30, 30));

    // Reset during the sweep restarts it from the beginning.
    drive(1'b0, 0, 32'h0, 1'b1, ra3(0, 0, 0));
    idle(10);
    rst_pulse();
    idle(36);

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_pulse();
      end else begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 63) == 0), 15'($urandom));
      end
    end

    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
